// File: rtl/dsram_pkg.sv
// dsram_pkg: shared constants and lane-merge helper for the data SRAM responder.
package dsram_pkg;

    localparam logic [11:0] OFF_TIMER   = 12'h000;
    localparam logic [11:0] OFF_COMPARE = 12'h004;
    localparam logic [11:0] OFF_CTRL    = 12'h008;
    localparam logic [11:0] OFF_STATUS  = 12'h00C;
    localparam logic [11:0] OFF_SCRATCH = 12'h010;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    localparam int CTRL_TMR_EN    = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int STATUS_PENDING = 0;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] be);
        merge_lanes = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) merge_lanes[8*i +: 8] = wdata[8*i +: 8];
    endfunction

endpackage

// File: rtl/dsram_timer.sv
// dsram_timer: MMIO register file with free-running timer, compare match and
// W1C pending flag driving a registered interrupt line.
module dsram_timer
    import dsram_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  we,
    input  logic [11:0] offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        timer_irq
);

    logic [31:0] timer;
    logic [31:0] compare;
    logic [31:0] scratch;
    logic [1:0]  ctrl;
    logic        pending;

    logic wr_timer, wr_compare, wr_scratch, wr_ctrl, clear, tmr_en, irq_en, match;

    assign wr_timer   = |we && offset == OFF_TIMER;
    assign wr_compare = |we && offset == OFF_COMPARE;
    assign wr_scratch = |we && offset == OFF_SCRATCH;
    assign wr_ctrl    = we[0] && offset == OFF_CTRL;
    assign clear      = we[0] && offset == OFF_STATUS && wdata[STATUS_PENDING];
    assign tmr_en     = ctrl[CTRL_TMR_EN];
    assign irq_en     = ctrl[CTRL_IRQ_EN];
    assign match      = tmr_en && timer == compare;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer     <= '0;
            compare   <= COMPARE_RST;
            scratch   <= '0;
            ctrl      <= '0;
            pending   <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            timer     <= wr_timer ? merge_lanes(timer, wdata, we) : timer + {31'b0, tmr_en};
            compare   <= wr_compare ? merge_lanes(compare, wdata, we) : compare;
            scratch   <= wr_scratch ? merge_lanes(scratch, wdata, we) : scratch;
            ctrl      <= wr_ctrl ? wdata[1:0] : ctrl;
            // a match in the same cycle as a W1C clear keeps the flag set
            pending   <= match | (pending & ~clear);
            timer_irq <= pending & irq_en;
        end
    end

    assign rdata = offset == OFF_TIMER   ? timer :
                   offset == OFF_COMPARE ? compare :
                   offset == OFF_CTRL    ? {30'b0, ctrl} :
                   offset == OFF_STATUS  ? {31'b0, pending} :
                   offset == OFF_SCRATCH ? scratch : '0;

endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: 1-cycle-latency byte-strobed data RAM responder; the timer MMIO
// window and timer_irq exist only when DSRAM_MMIO_EN is defined.
module data_sram_resp
    import dsram_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_F000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        timer_irq
);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              hit_mmio;
    logic              wr_ram;
    logic [31:0]       mmio_rdata;
    logic              unused_addr;

    assign idx         = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr, MMIO_BASE};

`ifdef DSRAM_MMIO_EN
    assign hit_mmio = data_sram_addr[31:12] == MMIO_BASE[31:12];

    dsram_timer u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .we        (data_sram_en && hit_mmio ? data_sram_we : 4'b0),
        .offset    (data_sram_addr[11:0]),
        .wdata     (data_sram_wdata),
        .rdata     (mmio_rdata),
        .timer_irq (timer_irq)
    );
`else
    assign hit_mmio   = 1'b0;
    assign mmio_rdata = '0;
    assign timer_irq  = 1'b0;
`endif

    assign wr_ram = data_sram_en && !hit_mmio && |data_sram_we;

    // RAM has no reset so it maps onto block RAM; a write during reset is dropped
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (resetn && wr_ram && data_sram_we[i])
                mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) data_sram_rdata <= '0;
        else if (data_sram_en) data_sram_rdata <= hit_mmio ? mmio_rdata : mem[idx];
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: randomized self-checking bench with a word-level RAM model;
// timer scenarios run when DSRAM_MMIO_EN is defined, macro-off checks otherwise.
module tb_data_sram_resp;

    localparam int          ADDR_W = 14;
    localparam logic [31:0] BASE   = 32'hBFAF_F000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = 4'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    bit [31:0] ref_mem [int];

    data_sram_resp #(.ADDR_W(ADDR_W), .MMIO_BASE(BASE)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .timer_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] r);
        en = e; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        r = rdata;
        en = 1'b0; we = 4'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference RAM: returns the word before the access and applies the write.
    task automatic ram_rw(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          output logic [31:0] old, output bit known);
        int k;
        logic [31:0] mask;
        k = int'((a >> 2) % (1 << ADDR_W));
        known = ref_mem.exists(k);
        old = known ? ref_mem[k] : 32'h0;
        mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        if (w != 0) begin
            ref_mem[k] = (old & ~mask) | (d & mask);
            if (!known && w != 4'hF) ref_mem.delete(k);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        #12;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk);
        resetn = 1'b1;
`ifdef DSRAM_MMIO_EN
        access(1, 0, BASE + 32'h04, 0, r);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare: got %h expected ffffffff", r); end
        access(1, 0, BASE + 32'h00, 0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_timer: got %h expected 0", r); end
        access(1, 0, BASE + 32'h08, 0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", r); end
        access(1, 0, BASE + 32'h10, 0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_scratch: got %h expected 0", r); end
`endif
    endtask

    task automatic test_byte_strobes();
        logic [31:0] r, old;
        bit known;
        ram_rw(32'h1C00_0100, 4'hF, 32'h1122_3344, old, known);
        access(1, 4'hF, 32'h1C00_0100, 32'h1122_3344, r);
        ram_rw(32'h1C00_0100, 4'b0101, 32'hAABB_CCDD, old, known);
        access(1, 4'b0101, 32'h1C00_0100, 32'hAABB_CCDD, r);
        checks++;
        if (r !== 32'h1122_3344) begin errors++; $display("FAIL strobe_read_first: got %h expected 11223344", r); end
        ram_rw(32'h1C00_0100, 4'h0, 0, old, known);
        access(1, 4'h0, 32'h1C00_0100, 0, r);
        checks++;
        if (r !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_merge: got %h expected 11bb33dd", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, old, v[3];
        bit known;
        for (int i = 0; i < 3; i++) begin
            v[i] = $urandom;
            ram_rw(32'(4 * i), 4'hF, v[i], old, known);
            access(1, 4'hF, 32'(4 * i), v[i], r);
        end
        for (int i = 0; i < 3; i++) begin
            access(1, 4'h0, 32'(4 * i), 0, r);
            checks++;
            if (r !== v[i]) begin errors++; $display("FAIL b2b_read%0d: got %h expected %h", i, r, v[i]); end
        end
        access(1, 4'h0, 32'h0 + (32'd4 << ADDR_W), 0, r);
        checks++;
        if (r !== v[0]) begin errors++; $display("FAIL alias_read: got %h expected %h", r, v[0]); end
    endtask

    task automatic test_random_ram();
        logic [31:0] base[8], r, old, last, a, d;
        logic [3:0] w;
        logic e;
        bit known;
        for (int i = 0; i < 8; i++) begin
            base[i] = $urandom & 32'h7FFF_FFFC;
            d = $urandom;
            ram_rw(base[i], 4'hF, d, old, known);
            access(1, 4'hF, base[i], d, r);
        end
        ram_rw(base[0], 0, 0, last, known);
        access(1, 0, base[0], 0, r);
        for (int n = 0; n < 80; n++) begin
            e = $urandom_range(0, 3) != 0;
            w = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            a = base[$urandom_range(0, 7)] ^ (32'($urandom_range(0, 3)) << (ADDR_W + 2));
            d = $urandom;
            if (e) ram_rw(a, w, d, last, known);
            access(e, w, a, d, r);
            checks++;
            if (r !== last) begin errors++; $display("FAIL random_ram[%0d]: got %h expected %h", n, r, last); end
`ifndef DSRAM_MMIO_EN
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL random_irq[%0d]: got %b expected 0", n, irq); end
`endif
        end
    endtask

`ifdef DSRAM_MMIO_EN
    task automatic test_mmio_regs();
        logic [31:0] r, s, d;
        logic [3:0] w;
        s = 32'h0;
        for (int n = 0; n < 6; n++) begin
            d = $urandom;
            w = 4'($urandom);
            s = (s & ~{{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}}) | (d & {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}});
            access(1, w, BASE + 32'h10, d, r);
            access(1, 0, BASE + 32'h10, 0, r);
            checks++;
            if (r !== s) begin errors++; $display("FAIL scratch[%0d]: got %h expected %h", n, r, s); end
        end
        access(1, 4'hF, BASE + 32'h14, 32'hDEAD_BEEF, r);
        access(1, 0, BASE + 32'h14, 0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL unmapped_offset: got %h expected 0", r); end
        access(1, 4'hF, BASE + 32'h08, 32'hFFFF_FFF2, r);
        access(1, 0, BASE + 32'h08, 0, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL ctrl_bits: got %h expected 2", r); end
        access(1, 4'hF, BASE + 32'h08, 0, r);
    endtask

    task automatic test_timer_wrap();
        logic [31:0] r, t;
        access(1, 4'hF, BASE + 32'h08, 32'h1, r);
        access(1, 4'hF, BASE + 32'h00, 32'hFFFF_FFFE, r);
        for (int k = 0; k < 3; k++) begin
            access(1, 0, BASE + 32'h00, 0, r);
            checks++;
            if (r !== 32'hFFFF_FFFE + 32'(k)) begin
                errors++; $display("FAIL timer_wrap[%0d]: got %h expected %h", k, r, 32'hFFFF_FFFE + 32'(k));
            end
        end
        t = $urandom;
        access(1, 4'hF, BASE + 32'h00, t, r);
        access(1, 0, BASE + 32'h00, 0, r);
        checks++;
        if (r !== t) begin errors++; $display("FAIL timer_write_counting: got %h expected %h", r, t); end
    endtask

    task automatic test_timer_match();
        logic [31:0] r;
        access(1, 4'hF, BASE + 32'h08, 0, r);
        access(1, 4'hF, BASE + 32'h00, 0, r);
        access(1, 4'hF, BASE + 32'h04, 5, r);
        access(1, 4'hF, BASE + 32'h0C, 1, r);
        access(1, 4'hF, BASE + 32'h08, 3, r);
        // counting starts from 0 after this write; TIMER==5 sits in the 6th cycle
        for (int k = 1; k <= 8; k++) begin
            idle_cycle();
            checks++;
            if (irq !== (k >= 7)) begin errors++; $display("FAIL match_irq[%0d]: got %b expected %b", k, irq, k >= 7); end
        end
        access(1, 0, BASE + 32'h0C, 0, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL match_status: got %h expected 1", r); end
    endtask

    task automatic test_w1c();
        logic [31:0] r;
        access(1, 4'hF, BASE + 32'h0C, 0, r);
        idle_cycle();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_zero_noeffect: got %b expected 1", irq); end
        access(1, 4'hF, BASE + 32'h0C, 1, r);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_plus1: got %b expected 1", irq); end
        idle_cycle();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_plus2: got %b expected 0", irq); end
        access(1, 0, BASE + 32'h0C, 0, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL w1c_status: got %h expected 0", r); end
    endtask

    task automatic test_priority();
        logic [31:0] r;
        access(1, 4'hF, BASE + 32'h04, 12, r);
        access(1, 4'hF, BASE + 32'h00, 10, r);
        access(0, 0, 0, 0, r);
        access(0, 0, 0, 0, r);
        access(1, 4'hF, BASE + 32'h0C, 1, r);
        access(1, 0, BASE + 32'h0C, 0, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL set_beats_clear: got %h expected 1", r); end
        idle_cycle();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL priority_irq: got %b expected 1", irq); end
    endtask
`else
    task automatic test_macro_off();
        logic [31:0] r, old, d;
        bit known;
        for (int n = 0; n < 4; n++) begin
            d = $urandom;
            ram_rw(BASE + 32'(4 * n), 4'hF, d, old, known);
            access(1, 4'hF, BASE + 32'(4 * n), d, r);
            ram_rw(BASE + 32'(4 * n), 4'h0, 0, old, known);
            access(1, 4'h0, BASE + 32'(4 * n), 0, r);
            checks++;
            if (r !== d) begin errors++; $display("FAIL base_as_ram[%0d]: got %h expected %h", n, r, d); end
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL off_irq[%0d]: got %b expected 0", n, irq); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] r, exp, old;
        bit known;
        ram_rw(32'h1C00_0100, 0, 0, exp, known);
        access(1, 0, 32'h1C00_0100, 0, r);
        en = 1'b1; we = 4'hF; addr = 32'h1C00_0100; wdata = ~exp;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", rdata); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; we = 4'h0; resetn = 1'b1;
        ram_rw(32'h1C00_0100, 0, 0, old, known);
        access(1, 0, 32'h1C00_0100, 0, r);
        checks++;
        if (r !== exp) begin errors++; $display("FAIL midreset_ram_kept: got %h expected %h", r, exp); end
`ifdef DSRAM_MMIO_EN
        access(1, 0, BASE + 32'h04, 0, r);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_compare: got %h expected ffffffff", r); end
`endif
    endtask

    initial begin
        test_reset();
        test_byte_strobes();
        test_back_to_back();
        test_random_ram();
`ifdef DSRAM_MMIO_EN
        test_mmio_regs();
        test_timer_wrap();
        test_timer_match();
        test_w1c();
        test_priority();
`else
        test_macro_off();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
